clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-keeping and time-setting controller for the clock design. It consumes the debounced key levels produced by the per-key debouncers and maintains the HH:MM:SS counters. It runs a seconds prescaler and sequences the RUN → SET_HOURS → SET_MINUTES → RUN editing cycle, with press-edge detection and hold-to-repeat. Its outputs drive the display formatter directly.

## Interface
- TICK_DIV, 50000000: clk_i cycles per second tick; must be ≥ 2
- REPEAT_DELAY, 25000000: cycles a step key must be held after its press before the first repeat step
- REPEAT_RATE, 10000000: cycles between subsequent repeat steps; must be ≥ 1
- BLINK_DIV, 12500000: cycles per blink_o half-period in set modes
- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low; clock clk_i
- mode_key_i  in  1  debounced mode key level, synchronous to clk_i
- inc_key_i  in  1  debounced increment key level, synchronous
- dec_key_i  in  1  debounced decrement key level, synchronous
- hours_o  out  5  hours, 0–23
- minutes_o  out  6  minutes, 0–59
- seconds_o  out  6  seconds, 0–59
- mode_o  out  2  0 = RUN, 1 = SET_HOURS, 2 = SET_MINUTES; 3 is never driven
- blink_o  out  1  display enable for the field being edited
- tick_o  out  1  one-cycle pulse per second tick, RUN only

## Operation
- Press detection: each key has a registered copy key_q. press = key_i & ~key_q. One press per rising level, regardless of hold length.
- FSM states: RUN, SET_HOURS, SET_MINUTES. A mode press advances RUN→SET_HOURS→SET_MINUTES→RUN. All other inputs leave the state unchanged.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At the wrap, tick_o = 1 for one cycle and seconds increment.
  - seconds 59→0 carries into minutes. minutes 59→0 carries into hours. 23:59:59 → 00:00:00.
  - inc/dec keys are ignored.
- SET_HOURS / SET_MINUTES:
  - Prescaler is held at 0 and tick_o stays 0.
  - inc step: field +1 (hours 23→0, minutes 59→0).
  - dec step: field −1 (hours 0→23, minutes 0→59).
  - No carry into other fields. Seconds are not altered.
- Leaving SET_MINUTES to RUN clears seconds to 0 and restarts the prescaler from 0.
- Auto-repeat:
  - A 32-bit hold counter starts at 0 on an inc or dec press.
  - While the same key stays high, an extra step occurs at count REPEAT_DELAY, then every REPEAT_RATE cycles after that.
  - The counter is cleared on key release, on any mode press, and in RUN.
- Simultaneous events:
  - inc and dec both high (press or held): no step, and the hold counter is cleared.
  - Mode press in the same cycle as an inc/dec press: the mode change wins and no step occurs.
- blink_o:
  - RUN: 1.
  - On entry to either set state: 1, with the blink counter cleared.
  - In set states: toggles every BLINK_DIV cycles.
- Prescaler, hold and blink counters are 32 bits. Field arithmetic uses explicit modulo compare; there is no binary overflow.

## Timing
- Reset values: hours_o = 0, minutes_o = 0, seconds_o = 0, mode_o = 0, blink_o = 1, tick_o = 0. All key_q registers = 0, all counters = 0.
- Key pressed across reset release: key_q = 0, so a key that is already high after reset counts as a press on the first clock.
- Registered outputs: a key first sampled high at edge N (low at N−1) updates mode_o or the edited field at edge N.
- First repeat step at edge N+REPEAT_DELAY. Later steps at N+REPEAT_DELAY+k·REPEAT_RATE.
- RUN tick timing:
  - tick_o is high in the cycle after the edge at which the prescaler reaches TICK_DIV-1.
  - seconds_o updates on the same edge as tick_o rises.
  - Tick period is exactly TICK_DIV cycles.
- After SET_MINUTES→RUN at edge M: first tick at edge M+TICK_DIV, seconds_o = 1 from then.
- Reset assertion mid-operation clears all state immediately (asynchronous). No partial step completes.

## Test plan
- Reset with TICK_DIV=4: outputs 00:00:00, mode_o=0, blink_o=1. Run 240 cycles → 00:01:00. tick_o asserted exactly 60 times, one cycle each.
- Preload 23:59:59 by running; next tick → 00:00:00, with minute and hour carries on the same edge.
- Mode press ×1 → mode_o=1. Dec press from hours 0 → 23. Inc press → 0. Mode press → mode_o=2, hours unchanged. Dec from minutes 0 → 59.
- REPEAT_DELAY=8, REPEAT_RATE=3, inc held 20 cycles in SET_MINUTES from 10: steps at offsets 0, 8, 11, 14, 17 → minutes_o=15. Release → no further change.
- Inc and dec pressed together → no change. Mode and inc pressed in the same cycle → mode advances, field unchanged.
- In SET_MINUTES, mode press → mode_o=0, seconds_o=0. tick_o first rises exactly TICK_DIV cycles later. Asserting rstn_i low mid-hold clears all outputs to reset values asynchronously.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// HH:MM:SS timekeeper with RUN -> SET_HOURS -> SET_MINUTES editing, key press edges and hold-to-repeat.
// Outputs are registered and update on the edge that samples the key. There is no backpressure: key levels are sampled every cycle.
module clock_set_ctrl #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 10000000,
    parameter int unsigned BLINK_DIV    = 12500000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       mode_key_i,
    input  logic       inc_key_i,
    input  logic       dec_key_i,
    output logic [4:0] hours_o,
    output logic [5:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic [1:0] mode_o,
    output logic       blink_o,
    output logic       tick_o
);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_SET_HOURS   = 2'd1,
        ST_SET_MINUTES = 2'd2
    } state_t;

    localparam logic [31:0] LP_TICK_MAX  = 32'(TICK_DIV - 1);
    localparam logic [31:0] LP_REP_FIRST = 32'(REPEAT_DELAY);
    localparam logic [31:0] LP_REP_WRAP  = 32'(REPEAT_DELAY + REPEAT_RATE);
    localparam logic [31:0] LP_BLINK_MAX = 32'(BLINK_DIV - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_mode_q;
    logic        r_inc_q;
    logic        r_dec_q;
    logic [31:0] r_presc;
    logic        r_tick;
    logic [31:0] r_hold;
    logic        r_hold_act;
    logic        r_hold_up;
    logic [31:0] r_blink_cnt;
    logic        r_blink;
    logic [4:0]  r_hours;
    logic [5:0]  r_minutes;
    logic [5:0]  r_seconds;

    logic        w_mode_press;
    logic        w_inc_press;
    logic        w_dec_press;
    logic        w_in_set;
    logic        w_both;
    logic        w_tick;
    logic        w_held_key;
    logic [31:0] w_hold_inc;
    logic [31:0] w_hold_nxt;
    logic        w_hold_act_nxt;
    logic        w_hold_up_nxt;
    logic        w_step_up;
    logic        w_step_dn;
    logic [4:0]  w_hours_inc;
    logic [4:0]  w_hours_dec;
    logic [5:0]  w_min_inc;
    logic [5:0]  w_min_dec;
    logic [5:0]  w_sec_inc;

    assign w_mode_press = mode_key_i & ~r_mode_q;
    assign w_inc_press  = inc_key_i & ~r_inc_q;
    assign w_dec_press  = dec_key_i & ~r_dec_q;
    assign w_in_set     = (r_state != ST_RUN);
    assign w_both       = inc_key_i & dec_key_i;
    assign w_tick       = (r_state == ST_RUN) && (r_presc == LP_TICK_MAX);
    assign w_held_key   = r_hold_up ? inc_key_i : dec_key_i;
    assign w_hold_inc   = r_hold + 32'd1;

    assign w_hours_inc = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
    assign w_hours_dec = (r_hours == 5'd0) ? 5'd23 : r_hours - 5'd1;
    assign w_min_inc   = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
    assign w_min_dec   = (r_minutes == 6'd0) ? 6'd59 : r_minutes - 6'd1;
    assign w_sec_inc   = (r_seconds == 6'd59) ? 6'd0 : r_seconds + 6'd1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_mode_press) begin
            case (r_state)
                ST_RUN:         w_state_nxt = ST_SET_HOURS;
                ST_SET_HOURS:   w_state_nxt = ST_SET_MINUTES;
                default:        w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Once the first repeat has fired the hold counter cycles REPEAT_DELAY..REPEAT_DELAY+REPEAT_RATE-1,
    // so it stays bounded however long the key is held.
    always_comb begin
        w_hold_nxt     = 32'd0;
        w_hold_act_nxt = 1'b0;
        w_hold_up_nxt  = r_hold_up;
        w_step_up      = 1'b0;
        w_step_dn      = 1'b0;
        if (w_in_set && !w_mode_press && !w_both) begin
            if (w_inc_press) begin
                w_step_up      = 1'b1;
                w_hold_act_nxt = 1'b1;
                w_hold_up_nxt  = 1'b1;
            end else if (w_dec_press) begin
                w_step_dn      = 1'b1;
                w_hold_act_nxt = 1'b1;
                w_hold_up_nxt  = 1'b0;
            end else if (r_hold_act && w_held_key) begin
                w_hold_act_nxt = 1'b1;
                if (w_hold_inc == LP_REP_WRAP) begin
                    w_hold_nxt = LP_REP_FIRST;
                    w_step_up  = r_hold_up;
                    w_step_dn  = ~r_hold_up;
                end else begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc == LP_REP_FIRST) begin
                        w_step_up = r_hold_up;
                        w_step_dn = ~r_hold_up;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mode_q   <= 1'b0;
            r_inc_q    <= 1'b0;
            r_dec_q    <= 1'b0;
            r_hold     <= 32'd0;
            r_hold_act <= 1'b0;
            r_hold_up  <= 1'b0;
        end else begin
            r_mode_q   <= mode_key_i;
            r_inc_q    <= inc_key_i;
            r_dec_q    <= dec_key_i;
            r_hold     <= w_hold_nxt;
            r_hold_act <= w_hold_act_nxt;
            r_hold_up  <= w_hold_up_nxt;
        end
    end

    // The prescaler idles at 0 in the set states, so RUN always restarts a full second.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_presc <= 32'd0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (r_state != ST_RUN || w_tick) begin
                r_presc <= 32'd0;
            end else begin
                r_presc <= r_presc + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_hours   <= 5'd0;
            r_minutes <= 6'd0;
            r_seconds <= 6'd0;
        end else if (w_tick) begin
            r_seconds <= w_sec_inc;
            if (r_seconds == 6'd59) begin
                r_minutes <= w_min_inc;
                if (r_minutes == 6'd59) begin
                    r_hours <= w_hours_inc;
                end
            end
        end else begin
            if (r_state == ST_SET_MINUTES && w_mode_press) begin
                r_seconds <= 6'd0;
            end
            if (r_state == ST_SET_HOURS) begin
                if (w_step_up) begin
                    r_hours <= w_hours_inc;
                end else if (w_step_dn) begin
                    r_hours <= w_hours_dec;
                end
            end
            if (r_state == ST_SET_MINUTES) begin
                if (w_step_up) begin
                    r_minutes <= w_min_inc;
                end else if (w_step_dn) begin
                    r_minutes <= w_min_dec;
                end
            end
        end
    end

    // Entering a set state restarts the blink phase with the field visible.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_blink_cnt <= 32'd0;
            r_blink     <= 1'b1;
        end else if (w_state_nxt == ST_RUN || w_state_nxt != r_state) begin
            r_blink_cnt <= 32'd0;
            r_blink     <= 1'b1;
        end else if (r_blink_cnt == LP_BLINK_MAX) begin
            r_blink_cnt <= 32'd0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
        end
    end

    assign hours_o   = r_hours;
    assign minutes_o = r_minutes;
    assign seconds_o = r_seconds;
    assign mode_o    = r_state;
    assign blink_o   = r_blink;
    assign tick_o    = r_tick;

endmodule
